// File: rtl/bit_4_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with a
// start/busy/done handshake and a divide-by-zero flag.
module bit_4_restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] q_sr, q_sr_n;
   logic [WIDTH-1:0] d_reg, d_reg_n;
   logic [WIDTH:0]   r_reg, r_reg_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] quotient_n, remainder_n;
   logic             done_n, dbz_n;

   logic [WIDTH:0]   rs, t, r_step;
   logic [WIDTH-1:0] q_step;
   logic             borrow;

   // Trial subtraction: the borrow out of the extra top bit selects keep vs restore.
   assign rs     = {r_reg[WIDTH-1:0], q_sr[WIDTH-1]};
   assign t      = rs - {1'b0, d_reg};
   assign borrow = t[WIDTH];
   assign r_step = borrow ? rs : t;
   assign q_step = {q_sr[WIDTH-2:0], ~borrow};

   assign busy = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n     = state;
      q_sr_n      = q_sr;
      d_reg_n     = d_reg;
      r_reg_n     = r_reg;
      cnt_n       = cnt;
      quotient_n  = quotient;
      remainder_n = remainder;
      dbz_n       = div_by_zero;
      done_n      = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  done_n      = 1'b1;
                  dbz_n       = 1'b1;
                  quotient_n  = '1;
                  remainder_n = dividend;
               end else begin
                  q_sr_n  = dividend;
                  d_reg_n = divisor;
                  r_reg_n = '0;
                  cnt_n   = CW'(WIDTH);
                  state_n = RUN;
               end
            end
         end
         RUN: begin
            q_sr_n  = q_step;
            r_reg_n = r_step;
            cnt_n   = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               quotient_n  = q_step;
               remainder_n = r_step[WIDTH-1:0];
               done_n      = 1'b1;
               dbz_n       = 1'b0;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_sr        <= '0;
         d_reg       <= '0;
         r_reg       <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         q_sr        <= q_sr_n;
         d_reg       <= d_reg_n;
         r_reg       <= r_reg_n;
         cnt         <= cnt_n;
         quotient    <= quotient_n;
         remainder   <= remainder_n;
         done        <= done_n;
         div_by_zero <= dbz_n;
      end
   end

endmodule

// File: tb/tb_bit_4_restoring_divider.sv
// Scoreboard bench for the restoring divider: expected results are queued at
// issue time and compared when done pulses.
module tb_bit_4_restoring_divider;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   done_cnt = 0;

   bit_4_restoring_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
      .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
      .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.a = a;
      e.b = b;
      if (b == 0) begin
         e.q = '1;
         e.r = a;
         e.z = 1'b1;
      end else begin
         e.q = W'(int'(a) / int'(b));
         e.r = W'(int'(a) % int'(b));
         e.z = 1'b0;
      end
      sb.push_back(e);
   endtask

   // Result monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (rst_n && done) begin
         exp_t e;
         done_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", div_by_zero, e.z);
            if (e.b != 0) begin
               chk("invariant", int'(quotient) * int'(e.b) + int'(remainder), e.a);
               chk("rem_lt_div", remainder < e.b, 1);
            end
         end
      end
   end

   // Issue one request (caller sits just after a rising edge) and wait for done.
   task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b);
      int n, nb;
      bit got;
      push(a, b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      n = 0; nb = 0; got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         n++;
         if (done) got = 1;
         else if (busy) nb++;
      end
      chk("done_seen", got, 1);
      chk("latency", n, (b == 0) ? 1 : W + 1);
      chk("busy_cycles", nb, (b == 0) ? 0 : W);
      chk("busy_at_done", busy, 0);
      @(posedge clk); #1;
      chk("done_pulse", done, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("q_hold", quotient, (b == 0) ? {W{1'b1}} : W'(int'(a) / int'(b)));
      chk("r_hold", remainder, (b == 0) ? a : W'(int'(a) % int'(b)));
   endtask

   initial begin
      int base, n;
      bit got;

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_one(4'd13, 4'd3);
      run_one(4'd15, 4'd1);
      run_one(4'd5,  4'd7);
      run_one(4'd0,  4'd9);
      run_one(4'd9,  4'd0);
      run_one(4'd8,  4'd2);

      // A request while busy must be ignored.
      base = done_cnt;
      push(4'd14, 4'd4);
      dividend = 4'd14; divisor = 4'd4; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      dividend = 4'd1; divisor = 4'd1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("busy_ignore_dones", done_cnt - base, 1);

      // Asynchronous reset in the middle of a run.
      base = done_cnt;
      dividend = 4'd12; divisor = 4'd5; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_q", quotient, 0);
      chk("arst_r", remainder, 0);
      chk("arst_dbz", div_by_zero, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt - base, 0);
      run_one(4'd12, 4'd5);

      // Exhaustive sweep, back-to-back with start held high.
      start = 1'b1;
      for (int idx = 0; idx < 256; idx++) begin
         logic [7:0] p;
         p = 8'(idx);
         dividend = p[7:4];
         divisor  = p[3:0];
         push(p[7:4], p[3:0]);
         n = 0; got = 0;
         for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            n++;
            if (done) got = 1;
         end
         chk("sweep_done", got, 1);
         chk("sweep_latency", n, (p[3:0] == 0) ? 1 : W + 1);
      end
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
